// File: rtl/sync_fifo_ram.sv
// Single-clock RAM-backed show-ahead FIFO with occupancy flags.
// Optional sticky error flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_ram #(
   parameter int SIZE         = 8,
   parameter int DEPTH        = 16,
   parameter int ALMOST_FULL  = 14,
   parameter int ALMOST_EMPTY = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [SIZE-1:0]            din,
   input  logic                       wput,
   output logic                       full,
   input  logic                       rget,
   output logic [SIZE-1:0]            dout,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full,
   output logic                       almost_empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   ,
   input  logic                       clr_err,
   output logic                       overflow,
   output logic                       underflow
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
   localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY);

   logic [SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   rd_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic            push_acc;
   logic            pop_acc;
   logic            bypass;
   logic            ld;

   assign full         = (cnt == DEPTH_C);
   assign empty        = (cnt == '0);
   assign almost_full  = (cnt >= AF_C);
   assign almost_empty = (cnt <= AE_C);
   assign count        = cnt;

   assign push_acc = wput & ~full;
   assign pop_acc  = rget & ~empty;

   // Next occupancy and look-ahead read address for the show-ahead register.
   always_comb begin
      cnt_nxt = cnt;
      rd_nxt  = rd_ptr;
      if (pop_acc) begin
         rd_nxt = rd_ptr + AW'(1);
      end
      case ({push_acc, pop_acc})
         2'b10:   cnt_nxt = cnt + CW'(1);
         2'b01:   cnt_nxt = cnt - CW'(1);
         default: cnt_nxt = cnt;
      endcase
   end

   // Write colliding with the next head must forward din; the RAM is read-old.
   // dout is only reloaded while something remains, so it holds when empty.
   assign bypass = push_acc & (wr_ptr == rd_nxt);
   assign ld     = (push_acc | pop_acc) & (cnt_nxt != '0);

   // Storage write port; left unreset so it can map to block RAM.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_nxt;
         cnt    <= cnt_nxt;
      end
   end

   // Registered read port with write-to-read forwarding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= '0;
      end else if (ld) begin
         dout <= bypass ? din : mem[rd_nxt];
      end
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   // Sticky misuse flags; a new event wins over a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wput & full) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (rget & empty) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed self-checking bench for sync_fifo_ram (DEPTH=16, SIZE=8).
// Covers error flags when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_ram;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       wput;
   logic       rget;
   logic       full;
   logic [7:0] dout;
   logic       empty;
   logic [4:0] count;
   logic       almost_full;
   logic       almost_empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic       clr_err;
   logic       overflow;
   logic       underflow;
`endif

   int n_chk;
   int n_fail;

   sync_fifo_ram #(
      .SIZE(8),
      .DEPTH(16),
      .ALMOST_FULL(14),
      .ALMOST_EMPTY(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .din(din),
      .wput(wput),
      .full(full),
      .rget(rget),
      .dout(dout),
      .empty(empty),
      .count(count),
      .almost_full(almost_full),
      .almost_empty(almost_empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      ,
      .clr_err(clr_err),
      .overflow(overflow),
      .underflow(underflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic w, input logic r,
                       input logic [7:0] d);
      wput = w;
      rget = r;
      din  = d;
      @(posedge clk);
      #1;
      wput = 1'b0;
      rget = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      din    = 8'h00;
      wput   = 1'b0;
      rget   = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      clr_err = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: reset state, then first push shows ahead next cycle
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_ae", 32'(almost_empty), 32'd1);
      check("rst_af", 32'(almost_full), 32'd0);
      check("rst_dout", 32'(dout), 32'h00);
      step(1'b1, 1'b0, 8'hA5);
      check("t1_empty", 32'(empty), 32'd0);
      check("t1_dout", 32'(dout), 32'hA5);
      check("t1_count", 32'(count), 32'd1);
      step(1'b0, 1'b1, 8'h00);
      check("t1_pop_empty", 32'(empty), 32'd1);
      check("t1_hold_dout", 32'(dout), 32'hA5);

      // 2: fill to full with threshold tracking, drop, drain in order
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 8'(i));
         check("t2_count", 32'(count), 32'(i + 1));
         check("t2_af", 32'(almost_full), 32'((i + 1) >= 14));
         check("t2_ae", 32'(almost_empty), 32'((i + 1) <= 2));
         check("t2_head", 32'(dout), 32'h00);
      end
      check("t2_full", 32'(full), 32'd1);
      step(1'b1, 1'b0, 8'hFF);
      check("t2_drop_count", 32'(count), 32'd16);
      check("t2_drop_full", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) begin
         check("t2_pop_data", 32'(dout), 32'(i));
         step(1'b0, 1'b1, 8'h00);
      end
      check("t2_drained", 32'(empty), 32'd1);
      check("t2_drained_cnt", 32'(count), 32'd0);

      // 3: sustained push+pop at count 1 across pointer wraps
      step(1'b1, 1'b0, 8'h40);
      check("t3_first", 32'(dout), 32'h40);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b1, 8'(8'h41 + i));
         check("t3_count", 32'(count), 32'd1);
         check("t3_dout", 32'(dout), 32'(8'h41 + i));
      end
      step(1'b0, 1'b1, 8'h00);
      check("t3_empty", 32'(empty), 32'd1);

      // 4: both requests when empty, then when full
      step(1'b1, 1'b1, 8'h3C);
      check("t4e_count", 32'(count), 32'd1);
      check("t4e_dout", 32'(dout), 32'h3C);
      check("t4e_empty", 32'(empty), 32'd0);
      for (int i = 0; i < 15; i++) begin
         step(1'b1, 1'b0, 8'(8'h50 + i));
      end
      check("t4f_full", 32'(full), 32'd1);
      step(1'b1, 1'b1, 8'h77);
      check("t4f_count", 32'(count), 32'd15);
      check("t4f_notfull", 32'(full), 32'd0);
      for (int i = 0; i < 15; i++) begin
         check("t4f_data", 32'(dout), 32'(8'h50 + i));
         step(1'b0, 1'b1, 8'h00);
      end
      check("t4f_empty", 32'(empty), 32'd1);

      // 5: asynchronous reset mid-burst
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 1'b0, 8'(8'h80 + i));
      end
      check("t5_pre_count", 32'(count), 32'd9);
      #2;
      rst = 1'b1;
      #1;
      check("t5_count", 32'(count), 32'd0);
      check("t5_empty", 32'(empty), 32'd1);
      check("t5_full", 32'(full), 32'd0);
      check("t5_ae", 32'(almost_empty), 32'd1);
      check("t5_dout", 32'(dout), 32'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 1'b0, 8'h11);
      step(1'b1, 1'b0, 8'h22);
      check("t5_first", 32'(dout), 32'h11);
      check("t5_count2", 32'(count), 32'd2);
      step(1'b0, 1'b1, 8'h00);
      check("t5_second", 32'(dout), 32'h22);
      step(1'b0, 1'b1, 8'h00);
      check("t5_empty2", 32'(empty), 32'd1);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
      // 6: sticky error flags
      check("t6_uf0", 32'(underflow), 32'd0);
      step(1'b0, 1'b1, 8'h00);
      check("t6_uf_set", 32'(underflow), 32'd1);
      step(1'b0, 1'b0, 8'h00);
      check("t6_uf_sticky", 32'(underflow), 32'd1);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 8'(i));
      end
      check("t6_of0", 32'(overflow), 32'd0);
      step(1'b1, 1'b0, 8'hEE);
      check("t6_of_set", 32'(overflow), 32'd1);
      check("t6_of_count", 32'(count), 32'd16);
      clr_err = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      clr_err = 1'b0;
      check("t6_clr_of", 32'(overflow), 32'd0);
      check("t6_clr_uf", 32'(underflow), 32'd0);
      clr_err = 1'b1;
      step(1'b1, 1'b0, 8'hEE);
      clr_err = 1'b0;
      check("t6_prio_of", 32'(overflow), 32'd1);
      check("t6_prio_uf", 32'(underflow), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
